dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive cycles a pending ext request may lose to the CPU before forced grant (range 1..15).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-003 clk  in  1  rising-edge clock shared with CPU pipeline.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cpu_re, cpu_we  in  1 each  CPU EX_DM-stage load/store request.
REQ-006 cpu_addr, cpu_wdata  in  16 each  CPU address and store data.
REQ-007 cpu_rdata  out  16  load data to CPU, valid the cycle after an accepted cpu_re.
REQ-008 cpu_stall  out  1  CPU must hold EX_DM request and stall pipeline.
REQ-009 ext_req, ext_we  in  1 each  secondary requester (debug/DMA) access request, write when ext_we=1.
REQ-010 ext_addr, ext_wdata  in  16 each  secondary address and write data.
REQ-011 ext_gnt  out  1  one-cycle pulse: ext request accepted and issued to DM this cycle.
REQ-012 ext_rdata  out  16; ext_rvalid  out  1  ext read data and one-cycle valid strobe.
REQ-013 dm_re, dm_we  out  1 each; dm_addr, dm_wdata  out  16 each; dm_rdata  in  16  data memory port; synchronous read, data on dm_rdata one cycle after dm_re.

Function
REQ-014 Ownership FSM states: CPU (default), EXT; one DM access per cycle, never both dm_re and dm_we.
REQ-015 CPU state: CPU request passed combinationally to DM port; ext_req pending and no CPU request -> ext issued same cycle (ext_gnt=1), state stays CPU.
REQ-016 CPU state, ext_req pending and CPU request present: CPU wins, starve counter increments; on reaching STARVE_MAX -> next cycle state EXT.
REQ-017 EXT state: ext request issued (ext_gnt=1), cpu_stall=1 if CPU request present, starve counter cleared, return to CPU next cycle.
REQ-018 Ext request sampled only while ext_req=1; requester holds ext_req/addr/data/we stable until ext_gnt.
REQ-019 Starve counter cleared whenever ext_gnt=1 or ext_req=0; 4-bit saturating, never wraps.
REQ-020 Read response routing: one-cycle flop records owner of the issued read; cpu_rdata and ext_rdata both driven from dm_rdata; ext_rvalid=1 exactly one cycle after an ext_gnt with ext_we=0.
REQ-021 Writes: no response strobe; ext_gnt with ext_we=1 completes the write.
REQ-022 cpu_stall never asserted in CPU state; asserted only in EXT state with cpu_re|cpu_we.
REQ-023 Simultaneous ext_req deassert while in EXT state: no DM access, ext_gnt=0, return to CPU.

Reset
REQ-024 rst_n low: state CPU, starve counter 0, response flop cleared; ext_gnt, ext_rvalid, cpu_stall = 0; dm_re/dm_we follow CPU requests only.
REQ-025 Reset mid-operation: pending ext read dropped, no ext_rvalid issued after reset release.

Configuration
REQ-026 Macro DM_ARB_FAIR_EN defined: starvation counter and EXT state implemented per REQ-016/017.
REQ-027 Macro DM_ARB_FAIR_EN undefined: strict CPU priority; ext served only in CPU-idle cycles; cpu_stall tied 0; counter and EXT state absent.

Structure
REQ-028 Shared package holds FSM state encoding (ARB_CPU, ARB_EXT) and DM address/data width constants (16).
REQ-029 One sub-module natural: dm_arb_starve_cnt (saturating counter with clear/inc, terminal-count output).

Verification
REQ-030 Ext read, CPU idle: ext_req=1, ext_addr=0x0040, DM[0x40]=0x1234 -> ext_gnt same cycle, ext_rvalid=1 and ext_rdata=0x1234 next cycle, cpu_stall=0.
REQ-031 CPU store vs ext read same cycle, STARVE_MAX=4: continuous cpu_we -> CPU served 4 cycles, cycle 5 EXT with cpu_stall=1, ext_gnt=1; cycle 6 CPU resumes.
REQ-032 DM_ARB_FAIR_EN undefined, continuous cpu_re 20 cycles with ext_req held -> ext_gnt never asserted, cpu_stall never asserted; first idle cycle -> ext_gnt=1.
REQ-033 CPU load 0x0010 (DM=0xBEEF) followed by ext read 0x0011 (DM=0x5A5A) -> cpu_rdata=0xBEEF with ext_rvalid=0, then ext_rvalid=1 with ext_rdata=0x5A5A.
REQ-034 Assert rst_n low the cycle after an ext read grant -> ext_rvalid stays 0, state CPU, counter 0 after release.
REQ-035 ext_req dropped in the cycle EXT is entered -> no DM access that cycle, ext_gnt=0, cpu_stall=0 next cycle.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU EX_DM stage
// and a secondary (debug/DMA) requester.
package dm_arbiter_pkg;

  localparam int unsigned DM_AW = 16;
  localparam int unsigned DM_DW = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_EXT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             re;
    logic             we;
    logic [DM_AW-1:0] addr;
    logic [DM_DW-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating starvation counter for the ext requester; only built when
// DM_ARB_FAIR_EN is defined (strict-priority builds carry no counter).
`ifdef DM_ARB_FAIR_EN
module dm_arb_starve_cnt
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the cycle whose increment makes the count reach MAX.
  assign tc_o = inc_i && (cnt_q >= CNT_W'(MAX - 1));

endmodule
`endif

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU has priority, ext requester uses idle cycles.
// Define DM_ARB_FAIR_EN to add the starvation counter and forced EXT turn.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [DM_AW-1:0] cpu_addr,
  input  logic [DM_DW-1:0] cpu_wdata,
  output logic [DM_DW-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [DM_AW-1:0] ext_addr,
  input  logic [DM_DW-1:0] ext_wdata,
  output logic             ext_gnt,
  output logic [DM_DW-1:0] ext_rdata,
  output logic             ext_rvalid,
  output logic             dm_re,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [DM_DW-1:0] dm_wdata,
  input  logic [DM_DW-1:0] dm_rdata
);

  logic    cpu_req;
  logic    cpu_sel;
  logic    ext_sel;
  logic    stall_c;
  logic    ext_rd_q;
  dm_req_t dm_req;

  assign cpu_req = cpu_re | cpu_we;

`ifdef DM_ARB_FAIR_EN
  arb_state_e state_q, state_d;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ARB_CPU;
    if ((state_q == ARB_CPU) && cpu_req && ext_req && cnt_tc) begin
      state_d = ARB_EXT;
    end
  end

  // The EXT turn is spent even if ext_req drops; the CPU then holds and retries.
  always_comb begin
    cpu_sel = 1'b0;
    ext_sel = 1'b0;
    stall_c = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b1;
    case (state_q)
      ARB_CPU: begin
        if (cpu_req) begin
          cpu_sel = 1'b1;
          cnt_inc = ext_req;
          cnt_clr = ~ext_req;
        end else begin
          ext_sel = ext_req & rst_n;
        end
      end
      ARB_EXT: begin
        ext_sel = ext_req;
        stall_c = cpu_req;
      end
    endcase
  end

  dm_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );
`else
  always_comb begin
    cpu_sel = cpu_req;
    ext_sel = ~cpu_req & ext_req & rst_n;
    stall_c = 1'b0;
  end
`endif

  // Single DM access per cycle; a load wins if the CPU ever raises both strobes.
  always_comb begin
    dm_req = '0;
    if (cpu_sel) begin
      dm_req = '{re: cpu_re, we: cpu_we & ~cpu_re, addr: cpu_addr, wdata: cpu_wdata};
    end else if (ext_sel) begin
      dm_req = '{re: ~ext_we, we: ext_we, addr: ext_addr, wdata: ext_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_rd_q <= 1'b0;
    end else begin
      ext_rd_q <= ext_sel & ~ext_we;
    end
  end

  assign dm_re      = dm_req.re;
  assign dm_we      = dm_req.we;
  assign dm_addr    = dm_req.addr;
  assign dm_wdata   = dm_req.wdata;
  assign ext_gnt    = ext_sel;
  assign cpu_stall  = stall_c;
  assign ext_rvalid = ext_rd_q;
  assign cpu_rdata  = dm_rdata;
  assign ext_rdata  = dm_rdata;

endmodule
